// File: rtl/pipe_sched.sv
// Pipeline scheduler: arbitrates stall sources, parks jump redirects, sequences trap flush/redirect.
// Latency: stall/flush/new_pc are combinational from inputs and state; a trap takes 2 cycles (flush, redirect).
// Backpressure: stall_o holds upstream stages; jumps seen under a partial (ID) stall are parked until the pipe runs.
//
// Ports: clk_i/rst_i (async, active-low); stall sources stallreq_from_id_i, exe_multi_start_i/exe_cycles_i,
//        mem_req_i/mem_ack_i; redirect sources jump_enable_i/jump_addr_i, trap_req_i.
//        Outputs stall_o[5:0] (pc,if,id,ex,mem,wb), flush_jump_o, flush_all_o, new_pc_o, exe_busy_o, bus_err_o.
// Option: define PIPE_SCHED_PERF_EN to add stall_cnt_o, a free-running count of stalled cycles.
module pipe_sched #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    CNT_WIDTH   = 6,
    parameter int                    MEM_TIMEOUT = 16,
    parameter logic [ADDR_WIDTH-1:0] TRAP_VECTOR = 32'h0000_0100
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  stallreq_from_id_i,
    input  logic                  exe_multi_start_i,
    input  logic [CNT_WIDTH-1:0]  exe_cycles_i,
    input  logic                  mem_req_i,
    input  logic                  mem_ack_i,
    input  logic                  jump_enable_i,
    input  logic [ADDR_WIDTH-1:0] jump_addr_i,
    input  logic                  trap_req_i,
    output logic [5:0]            stall_o,
    output logic                  flush_jump_o,
    output logic                  flush_all_o,
    output logic [ADDR_WIDTH-1:0] new_pc_o,
    output logic                  exe_busy_o,
    output logic                  bus_err_o
`ifdef PIPE_SCHED_PERF_EN
    ,
    output logic [31:0]           stall_cnt_o
`endif
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        EXE_WAIT   = 2'd1,
        TRAP_FLUSH = 2'd2,
        REDIRECT   = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] MEM_TO = CNT_WIDTH'(MEM_TIMEOUT);

    state_t                state, state_nxt;
    logic [CNT_WIDTH-1:0]  exe_cnt, exe_cnt_nxt;
    logic [CNT_WIDTH-1:0]  mem_cnt, mem_cnt_nxt, mem_cnt_inc;
    logic                  pend_vld, pend_vld_nxt;
    logic [ADDR_WIDTH-1:0] pend_addr, pend_addr_nxt;
    logic                  bus_err_nxt;
    logic                  mem_wait, timeout, trap_go;
    logic [5:0]            stall_raw;
    logic                  flush_jump_raw, flush_all_raw;
    logic [ADDR_WIDTH-1:0] new_pc_raw;

    assign mem_wait    = mem_req_i & ~mem_ack_i;
    assign mem_cnt_inc = mem_cnt + 1'b1;
    // mem_cnt only reaches MEM_TO for the single cycle after the last waited cycle
    assign timeout     = (mem_cnt == MEM_TO);
    assign trap_go     = trap_req_i | timeout;

    always_comb begin
        state_nxt      = state;
        exe_cnt_nxt    = exe_cnt;
        mem_cnt_nxt    = mem_cnt;
        pend_vld_nxt   = pend_vld;
        pend_addr_nxt  = pend_addr;
        bus_err_nxt    = 1'b0;
        stall_raw      = 6'b000000;
        flush_jump_raw = 1'b0;
        flush_all_raw  = 1'b0;
        new_pc_raw     = jump_addr_i;

        case (state)
            IDLE, EXE_WAIT: begin
                if (trap_go) begin
                    // trap beats everything: same-cycle jump, parked jump and EX count are dropped
                    state_nxt    = TRAP_FLUSH;
                    pend_vld_nxt = 1'b0;
                    exe_cnt_nxt  = '0;
                    mem_cnt_nxt  = '0;
                end else begin
                    mem_cnt_nxt = mem_wait ? mem_cnt_inc : '0;
                    bus_err_nxt = mem_wait && (mem_cnt_inc == MEM_TO);

                    if (mem_wait)
                        stall_raw = 6'b011111;
                    else if (state == EXE_WAIT)
                        stall_raw = 6'b001111;
                    else if (stallreq_from_id_i)
                        stall_raw = 6'b000111;

                    if (state == EXE_WAIT) begin
                        // a new start pulse while busy is ignored
                        exe_cnt_nxt = exe_cnt - 1'b1;
                        if (exe_cnt <= 1)
                            state_nxt = IDLE;
                    end else if (exe_multi_start_i && (exe_cycles_i != '0)) begin
                        exe_cnt_nxt = exe_cycles_i;
                        state_nxt   = EXE_WAIT;
                    end

                    if (stall_raw == 6'b000000) begin
                        // a fresh jump is younger than a parked one, so it takes the redirect
                        if (jump_enable_i) begin
                            flush_jump_raw = 1'b1;
                            new_pc_raw     = jump_addr_i;
                            pend_vld_nxt   = 1'b0;
                        end else if (pend_vld) begin
                            flush_jump_raw = 1'b1;
                            new_pc_raw     = pend_addr;
                            pend_vld_nxt   = 1'b0;
                        end
                    end else if (jump_enable_i && !stall_raw[3]) begin
                        // EX is moving on, so this jump won't be re-presented: park it
                        pend_vld_nxt  = 1'b1;
                        pend_addr_nxt = jump_addr_i;
                    end
                    // with EX held, the branch stays in EX and will be presented again
                end
            end
            TRAP_FLUSH: begin
                flush_all_raw = 1'b1;
                pend_vld_nxt  = 1'b0;
                exe_cnt_nxt   = '0;
                mem_cnt_nxt   = '0;
                state_nxt     = REDIRECT;
            end
            REDIRECT: begin
                flush_jump_raw = 1'b1;
                new_pc_raw     = TRAP_VECTOR;
                state_nxt      = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state     <= IDLE;
            exe_cnt   <= '0;
            mem_cnt   <= '0;
            pend_vld  <= 1'b0;
            pend_addr <= '0;
            bus_err_o <= 1'b0;
        end else begin
            state     <= state_nxt;
            exe_cnt   <= exe_cnt_nxt;
            mem_cnt   <= mem_cnt_nxt;
            pend_vld  <= pend_vld_nxt;
            pend_addr <= pend_addr_nxt;
            bus_err_o <= bus_err_nxt;
        end
    end

    // combinational outputs are forced quiet while reset is asserted
    assign stall_o      = rst_i ? stall_raw      : 6'b000000;
    assign flush_jump_o = rst_i ? flush_jump_raw : 1'b0;
    assign flush_all_o  = rst_i ? flush_all_raw  : 1'b0;
    assign new_pc_o     = rst_i ? new_pc_raw     : '0;
    assign exe_busy_o   = (state == EXE_WAIT);

`ifdef PIPE_SCHED_PERF_EN
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)
            stall_cnt_o <= 32'd0;
        else if (stall_raw != 6'b000000)
            stall_cnt_o <= stall_cnt_o + 32'd1;
    end
`endif

endmodule

// File: tb/tb_pipe_sched.sv
// Directed bench for pipe_sched: stall priority, EX count, jump parking, MEM timeout, trap sequencing, reset.
// Inputs change 1 time unit after the rising edge; outputs are compared on the falling edge.
// Every comparison goes through chk(), which feeds the summary counters.
module tb_pipe_sched;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        stallreq_from_id_i;
    logic        exe_multi_start_i;
    logic [5:0]  exe_cycles_i;
    logic        mem_req_i;
    logic        mem_ack_i;
    logic        jump_enable_i;
    logic [31:0] jump_addr_i;
    logic        trap_req_i;
    logic [5:0]  stall_o;
    logic        flush_jump_o;
    logic        flush_all_o;
    logic [31:0] new_pc_o;
    logic        exe_busy_o;
    logic        bus_err_o;
`ifdef PIPE_SCHED_PERF_EN
    logic [31:0] stall_cnt_o;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_i = ~clk_i;

    pipe_sched dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .stallreq_from_id_i (stallreq_from_id_i),
        .exe_multi_start_i  (exe_multi_start_i),
        .exe_cycles_i       (exe_cycles_i),
        .mem_req_i          (mem_req_i),
        .mem_ack_i          (mem_ack_i),
        .jump_enable_i      (jump_enable_i),
        .jump_addr_i        (jump_addr_i),
        .trap_req_i         (trap_req_i),
        .stall_o            (stall_o),
        .flush_jump_o       (flush_jump_o),
        .flush_all_o        (flush_all_o),
        .new_pc_o           (new_pc_o),
        .exe_busy_o         (exe_busy_o),
        .bus_err_o          (bus_err_o)
`ifdef PIPE_SCHED_PERF_EN
        ,
        .stall_cnt_o        (stall_cnt_o)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // advance to just after the next rising edge
    task automatic nxt();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        @(negedge clk_i);
    endtask

    initial begin
        rst_i              = 1'b0;
        stallreq_from_id_i = 1'b0;
        exe_multi_start_i  = 1'b0;
        exe_cycles_i       = 6'd0;
        mem_req_i          = 1'b0;
        mem_ack_i          = 1'b0;
        jump_enable_i      = 1'b1;
        jump_addr_i        = 32'h55;
        trap_req_i         = 1'b0;

        // reset: outputs quiet even with a jump presented
        settle();
        chk("rst_stall", 32'(stall_o), 32'h0);
        chk("rst_flush_jump", 32'(flush_jump_o), 32'h0);
        chk("rst_flush_all", 32'(flush_all_o), 32'h0);
        chk("rst_new_pc", new_pc_o, 32'h0);
        chk("rst_busy", 32'(exe_busy_o), 32'h0);
        chk("rst_bus_err", 32'(bus_err_o), 32'h0);
        nxt();
        rst_i         = 1'b1;
        jump_enable_i = 1'b0;
        jump_addr_i   = 32'h1234;
        settle();
        chk("idle_stall", 32'(stall_o), 32'h0);
        chk("idle_new_pc", new_pc_o, 32'h1234);
        chk("idle_flush_jump", 32'(flush_jump_o), 32'h0);

        // ID hazard for exactly 2 cycles
        nxt();
        stallreq_from_id_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            settle();
            chk("id_stall", 32'(stall_o), 32'h07);
            nxt();
        end
        stallreq_from_id_i = 1'b0;
        settle();
        chk("id_release", 32'(stall_o), 32'h0);

        // EX op, 5 cycles
        nxt();
        exe_multi_start_i = 1'b1;
        exe_cycles_i      = 6'd5;
        settle();
        chk("ex_start_cycle", 32'(stall_o), 32'h0);
        nxt();
        exe_multi_start_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            settle();
            chk("ex_stall", 32'(stall_o), 32'h0F);
            chk("ex_busy", 32'(exe_busy_o), 32'h1);
            nxt();
        end
        settle();
        chk("ex_done_stall", 32'(stall_o), 32'h0);
        chk("ex_done_busy", 32'(exe_busy_o), 32'h0);

        // jump under EX stall is dropped (EX re-presents it)
        nxt();
        exe_multi_start_i = 1'b1;
        exe_cycles_i      = 6'd3;
        nxt();
        exe_multi_start_i = 1'b0;
        jump_enable_i     = 1'b1;
        jump_addr_i       = 32'h300;
        settle();
        chk("ex_jump_no_flush", 32'(flush_jump_o), 32'h0);
        nxt();
        jump_enable_i = 1'b0;
        jump_addr_i   = 32'h0;
        nxt();
        nxt();
        settle();
        chk("ex_jump_dropped_stall", 32'(stall_o), 32'h0);
        chk("ex_jump_dropped", 32'(flush_jump_o), 32'h0);

        // jump under ID stall is parked, issued once when the pipe runs
        nxt();
        stallreq_from_id_i = 1'b1;
        jump_enable_i      = 1'b1;
        jump_addr_i        = 32'h400;
        settle();
        chk("park_stall", 32'(stall_o), 32'h07);
        chk("park_no_flush", 32'(flush_jump_o), 32'h0);
        nxt();
        stallreq_from_id_i = 1'b0;
        jump_enable_i      = 1'b0;
        jump_addr_i        = 32'h999;
        settle();
        chk("park_issue", 32'(flush_jump_o), 32'h1);
        chk("park_issue_pc", new_pc_o, 32'h400);
        nxt();
        settle();
        chk("park_once", 32'(flush_jump_o), 32'h0);
        chk("park_once_pc", new_pc_o, 32'h999);

        // zero-latency jump
        nxt();
        jump_enable_i = 1'b1;
        jump_addr_i   = 32'h800;
        settle();
        chk("jump_direct", 32'(flush_jump_o), 32'h1);
        chk("jump_direct_pc", new_pc_o, 32'h800);

        // last parked jump wins
        nxt();
        stallreq_from_id_i = 1'b1;
        jump_addr_i        = 32'h10;
        nxt();
        jump_addr_i = 32'h20;
        nxt();
        stallreq_from_id_i = 1'b0;
        jump_enable_i      = 1'b0;
        jump_addr_i        = 32'h0;
        settle();
        chk("overwrite_flush", 32'(flush_jump_o), 32'h1);
        chk("overwrite_pc", new_pc_o, 32'h20);

        // N=0 start does nothing
        nxt();
        exe_multi_start_i = 1'b1;
        exe_cycles_i      = 6'd0;
        nxt();
        exe_multi_start_i = 1'b0;
        settle();
        chk("n0_stall", 32'(stall_o), 32'h0);
        chk("n0_busy", 32'(exe_busy_o), 32'h0);

        // ack clears the timeout counter: 10 + 15 waited cycles, no error
        nxt();
        mem_req_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            settle();
            chk("mem_wait_a", 32'(stall_o), 32'h1F);
            nxt();
        end
        mem_ack_i = 1'b1;
        settle();
        chk("mem_ack_stall", 32'(stall_o), 32'h0);
        nxt();
        mem_ack_i = 1'b0;
        for (int i = 0; i < 15; i++) begin
            settle();
            chk("mem_wait_b_err", 32'(bus_err_o), 32'h0);
            nxt();
        end
        mem_req_i = 1'b0;
        settle();
        chk("mem_drop_stall", 32'(stall_o), 32'h0);
        nxt();
        settle();
        chk("mem_no_err", 32'(bus_err_o), 32'h0);

        // MEM timeout: 16 stalled cycles, error, flush, redirect
        nxt();
        mem_req_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            settle();
            chk("to_stall", 32'(stall_o), 32'h1F);
            chk("to_no_err", 32'(bus_err_o), 32'h0);
            nxt();
        end
        settle();
        chk("to_bus_err", 32'(bus_err_o), 32'h1);
        chk("to_err_stall", 32'(stall_o), 32'h0);
        chk("to_err_flush_all", 32'(flush_all_o), 32'h0);
        nxt();
        mem_req_i = 1'b0;
        settle();
        chk("to_flush_all", 32'(flush_all_o), 32'h1);
        chk("to_err_pulse", 32'(bus_err_o), 32'h0);
        nxt();
        settle();
        chk("to_redirect", 32'(flush_jump_o), 32'h1);
        chk("to_redirect_pc", new_pc_o, 32'h100);
        nxt();
        settle();
        chk("to_idle_flush", 32'(flush_jump_o), 32'h0);

        // trap beats a simultaneous jump; trap during flush/redirect ignored
        nxt();
        trap_req_i    = 1'b1;
        jump_enable_i = 1'b1;
        jump_addr_i   = 32'h200;
        settle();
        chk("trap_no_jump", 32'(flush_jump_o), 32'h0);
        chk("trap_stall", 32'(stall_o), 32'h0);
        nxt();
        jump_enable_i = 1'b0;
        jump_addr_i   = 32'h777;
        settle();
        chk("trap_flush_all", 32'(flush_all_o), 32'h1);
        chk("trap_flush_nojump", 32'(flush_jump_o), 32'h0);
        nxt();
        settle();
        chk("trap_redirect", 32'(flush_jump_o), 32'h1);
        chk("trap_redirect_pc", new_pc_o, 32'h100);
        nxt();
        trap_req_i = 1'b0;
        settle();
        chk("trap_retrigger", 32'(flush_all_o), 32'h0);
        chk("trap_no_200", 32'(flush_jump_o), 32'h0);

        // trap discards an EX op in progress
        nxt();
        exe_multi_start_i = 1'b1;
        exe_cycles_i      = 6'd5;
        nxt();
        exe_multi_start_i = 1'b0;
        nxt();
        trap_req_i = 1'b1;
        nxt();
        trap_req_i = 1'b0;
        settle();
        chk("trap_ex_flush", 32'(flush_all_o), 32'h1);
        nxt();
        nxt();
        settle();
        chk("trap_ex_stall", 32'(stall_o), 32'h0);
        chk("trap_ex_busy", 32'(exe_busy_o), 32'h0);

        // reset mid EXE_WAIT with 3 cycles left
        nxt();
        exe_multi_start_i = 1'b1;
        exe_cycles_i      = 6'd5;
        nxt();
        exe_multi_start_i = 1'b0;
        nxt();
        nxt();
        rst_i = 1'b0;
        #1;
        chk("rst_mid_stall", 32'(stall_o), 32'h0);
        chk("rst_mid_busy", 32'(exe_busy_o), 32'h0);
        nxt();
        rst_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("post_rst_stall", 32'(stall_o), 32'h0);
            nxt();
        end

`ifdef PIPE_SCHED_PERF_EN
        chk("perf_after_rst", stall_cnt_o, 32'd0);
        stallreq_from_id_i = 1'b1;
        nxt();
        nxt();
        nxt();
        stallreq_from_id_i = 1'b0;
        settle();
        chk("perf_count", stall_cnt_o, 32'd3);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
